// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq
//
// Iterative shift-add multiplier. It produces a full 2*WIDTH-bit product in
// WIDTH+1 cycles using a single WIDTH+1-bit adder. Each operation can be
// signed (two's complement) or unsigned. Signed operands are converted to
// magnitudes when they are accepted. The product sign is applied once, in the
// final FIX cycle.
//
// Ports:
//   CLK     in   clock, rising-edge active
//   RST     in   asynchronous active-low reset
//   START   in   request a multiply (sampled only while READY=1)
//   SIGNED  in   1 = two's-complement operands, 0 = unsigned
//   A       in   multiplicand (WIDTH bits)
//   B       in   multiplier (WIDTH bits)
//   READY   out  idle and able to accept START
//   DONE    out  one-cycle pulse when HI/LO carry a fresh result
//   HI      out  upper WIDTH bits of the product
//   LO      out  lower WIDTH bits of the product
// -----------------------------------------------------------------------------
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [CW-1:0]      count;
    logic               neg;

    logic               load;
    logic               step;
    logic               finish;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;

    // The most negative value negates to 2^(WIDTH-1). That still fits the
    // unsigned magnitude register, so no operand needs special handling.
    assign a_mag = (SIGNED && A[WIDTH-1]) ? -A : A;
    assign b_mag = (SIGNED && B[WIDTH-1]) ? -B : B;

    // The carry out of this add becomes the new MSB of acc_hi when the
    // {carry, acc_hi, mplier} chain shifts right. The multiplier register
    // fills with product LSBs as its own bits are consumed.
    assign sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    assign product = {acc_hi, mplier};
    assign result  = neg ? -product : product;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        READY      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                if (START) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == LAST) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // HI/LO change only on the FIX edge, so they hold the previous result
    // for the whole of the next calculation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            count  <= '0;
            neg    <= 1'b0;
            DONE   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            DONE <= finish;
            if (load) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                acc_hi <= '0;
                count  <= '0;
                neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            end
            if (step) begin
                acc_hi <= sum[WIDTH:1];
                mplier <= {sum[0], mplier[WIDTH-1:1]};
                count  <= count + CW'(1);
            end
            if (finish) begin
                HI <= result[2*WIDTH-1:WIDTH];
                LO <= result[WIDTH-1:0];
            end
        end
    end

endmodule
